// File: rtl/sha2_pkg.sv
// Shared constants for the SHA2 front end: padder state encoding and
// block layout positions.
`timescale 1ns/1ps
package sha2_pkg;

  localparam logic [1:0] ST_FILL = 2'd0;
  localparam logic [1:0] ST_PAD  = 2'd1;
  localparam logic [1:0] ST_LEN  = 2'd2;
  localparam logic [1:0] ST_EMIT = 2'd3;

  localparam logic [7:0] PAD_BYTE = 8'h80;
  localparam int         LEN_POS  = 56;
  localparam int         BLK_W    = 512;

endpackage

// File: rtl/sha2_msg_padder.sv
// Byte-stream SHA-256 message padder: collects bytes into 512-bit blocks,
// appends the 0x80 marker and the 64-bit big-endian bit length.
`timescale 1ns/1ps
module sha2_msg_padder
  import sha2_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  input  logic             in_empty,
  output logic             blk_valid,
  input  logic             blk_ready,
  output logic [BLK_W-1:0] blk_data,
  output logic             blk_last
);

  logic [1:0]       state;
  logic [BLK_W-1:0] blk_buf;
  logic [5:0]       ptr;
  logic [LEN_W-1:0] len;
  logic             pend_pad;
  logic             pend_len;
  logic             last_q;

  // reset gates in_ready so nothing looks acceptable while reset is held low
  assign in_ready  = reset && (state == ST_FILL);
  assign blk_valid = (state == ST_EMIT);
  assign blk_data  = blk_buf;
  assign blk_last  = last_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_FILL;
      blk_buf  <= '0;
      ptr      <= '0;
      len      <= '0;
      pend_pad <= 1'b0;
      pend_len <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      case (state)
        ST_FILL: begin
          if (in_valid && in_ready) begin
            if (!in_empty) begin
              blk_buf[BLK_W-1-8*int'(ptr) -: 8] <= in_data;
              ptr <= ptr + 6'd1;
              len <= len + LEN_W'(8);
              if (ptr == 6'd63) begin
                state    <= ST_EMIT;
                last_q   <= 1'b0;
                pend_pad <= in_last;
              end else if (in_last) begin
                state <= ST_PAD;
              end
            end else if (in_last) begin
              state <= ST_PAD;
            end
          end
        end

        // marker always fits; the length only fits if the marker sits before byte 56
        ST_PAD: begin
          blk_buf[BLK_W-1-8*int'(ptr) -: 8] <= PAD_BYTE;
          pend_pad <= 1'b0;
          state    <= ST_EMIT;
          if (ptr <= 6'(LEN_POS - 1)) begin
            blk_buf[LEN_W-1:0] <= len;
            last_q   <= 1'b1;
            pend_len <= 1'b0;
          end else begin
            last_q   <= 1'b0;
            pend_len <= 1'b1;
          end
        end

        ST_LEN: begin
          blk_buf[LEN_W-1:0] <= len;
          last_q   <= 1'b1;
          pend_len <= 1'b0;
          state    <= ST_EMIT;
        end

        default: begin
          if (blk_ready) begin
            blk_buf <= '0;
            ptr     <= '0;
            if (last_q) begin
              len    <= '0;
              last_q <= 1'b0;
              state  <= ST_FILL;
            end else if (pend_pad) begin
              state <= ST_PAD;
            end else if (pend_len) begin
              state <= ST_LEN;
            end else begin
              state <= ST_FILL;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/sha2_msg_padder.md
# sha2_msg_padder

Byte-stream front end for the SHA2 compression core. Accepts a message one byte per cycle, applies FIPS 180-4 padding (0x80 marker, zero fill, 64-bit big-endian bit length) and presents complete 512-bit blocks to the core over a valid/ready handshake. It is the producer side of the core's `message` input and removes hand-built padded vectors from the bench.

## Interface
- `LEN_W`, 64: width of the bit-length counter, fixed by SHA-256.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low.
- `in_valid` input 1: input beat present.
- `in_ready` output 1: padder accepts a beat this cycle.
- `in_data` input 8: message byte.
- `in_last` input 1: final beat of the message.
- `in_empty` input 1: beat carries no byte; legal only with `in_last`, used for zero-length messages.
- `blk_valid` output 1: `blk_data` holds a complete block.
- `blk_ready` input 1: core takes the block.
- `blk_data` output 512: block, byte 0 in bits [511:504].
- `blk_last` output 1: this block is the final block of the message.

## Operation
- Registers: 512-bit buffer, 6-bit byte pointer `ptr`, 64-bit bit counter `len`, pending flags.
- States: FILL, PAD, LEN, EMIT.
- FILL:
  - `in_ready`=1.
  - On a handshake with `in_empty`=0, write `in_data` at byte `ptr`, increment `ptr`, and add 8 to `len`.
  - When the byte is written at `ptr`=63:
    - without `in_last`: go to EMIT with `blk_last`=0, then return to FILL.
    - with `in_last`: go to EMIT with `blk_last`=0 and pad pending, then go to PAD with `ptr`=0.
  - A byte with `in_last` at `ptr`<63 goes to PAD.
  - `in_last` with `in_empty` goes to PAD without a write.
- PAD, one cycle:
  - Write 0x80 at byte `ptr`.
  - If `ptr`<=55, write `len` big-endian into bytes 56..63 and go to EMIT with `blk_last`=1.
  - Otherwise go to EMIT with `blk_last`=0 and length pending; after the handshake, go to LEN.
- LEN, one cycle: write `len` into bytes 56..63 of the zeroed buffer, then go to EMIT with `blk_last`=1.
- EMIT:
  - `blk_valid`=1.
  - `blk_data` and `blk_last` are held stable until `blk_ready`.
  - On handshake, clear the buffer to zero, set `ptr`=0, and go to the pending state.
  - After a final block, clear `len` and go to FILL.
- `len` is modulo 2^64 and wraps silently.

## Timing
- Reset values: `in_ready`=0 while `reset` is low, then 1 in FILL; `blk_valid`=0; `blk_last`=0; `blk_data`=0.
- All registers, including `len` and `ptr`, clear to zero; state resets to FILL.
- `in_ready` is a registered-state decode: 1 only in FILL, 0 in PAD/LEN/EMIT.
- Latency:
  - Last byte accepted at cycle N: PAD at N+1, `blk_valid` at N+2.
  - Full non-final block: byte 63 accepted at N, `blk_valid` at N+1.
  - Second pad block: LEN one cycle after the handshake, `blk_valid` two cycles after it.
- Backpressure: `blk_ready` low holds EMIT indefinitely; no input is accepted.
- `blk_ready` is ignored when `blk_valid`=0.
- Reset asserted mid-message or mid-EMIT drops the block immediately and clears all state.

## Structure
- Shared package `sha2_pkg`:
  - state encoding FILL/PAD/LEN/EMIT.
  - `PAD_BYTE`=8'h80.
  - `LEN_POS`=56.
  - `BLK_W`=512.
- Single module, no sub-module.
- Byte-lane write is an indexed part-select on the buffer.

## Test plan
- "abc" (61 62 63, `in_last` on 63):
  - One block 616263 80, zeros, then 00..0018.
  - `blk_last`=1, `blk_valid` two cycles after the last byte.
- 26 bytes a..z:
  - Block 6162..797a 80, zeros, then 00..00d0.
  - Must equal the core's known "a..z" vector.
- 56 bytes: two blocks.
  - Block 1: data, 80, seven zero bytes, `blk_last`=0.
  - Block 2: zeros and length 0x1c0, `blk_last`=1.
- 64 bytes: two blocks.
  - Block 1: pure data, `blk_last`=0.
  - Block 2: 80, zeros, length 0x200, `blk_last`=1.
- Empty message (`in_last`+`in_empty`): single block 80 followed by 63 zero bytes (length field zero).
- Backpressure and reset:
  - Hold `blk_ready` low 5 cycles: `blk_data` stable, `in_ready`=0.
  - Assert `reset` after 10 bytes: all outputs zero.
  - Then "abc" produces the correct block.
